// File: rtl/sram_write_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_write_monitor                                           |
// | Description : Watches the SRAM write port, sorts writes into address       |
// |               regions, checks sequential order, counts writes and folds    |
// |               written data into a per-region rotate/XOR signature.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_write_monitor #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int NUM_REGIONS = 3,
  parameter int CNT_W       = 18,
  parameter int OOR_W       = 16
) (
  input  logic                          Clock_50,
  input  logic                          Reset,
  input  logic                          Enable,
  input  logic                          SRAM_we_n,
  input  logic [ADDR_W-1:0]             SRAM_address,
  input  logic [DATA_W-1:0]             SRAM_write_data,
  input  logic [NUM_REGIONS*ADDR_W-1:0] Region_base,
  input  logic [NUM_REGIONS*CNT_W-1:0]  Region_size,
  input  logic [NUM_REGIONS*DATA_W-1:0] Expected_sig,
  output logic [NUM_REGIONS-1:0]        Region_done,
  output logic [NUM_REGIONS-1:0]        Region_fail,
  output logic                          All_pass,
  output logic [OOR_W-1:0]              Out_of_region_count,
  output logic                          First_err_valid,
  output logic [ADDR_W-1:0]             First_err_address,
  output logic [1:0]                    Monitor_state
);

  // Region bounds are compared one bit wider than either operand so base+size never wraps.
  localparam int CMP_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MON  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  logic                enable_q;
  logic                s1_valid;
  logic [ADDR_W-1:0]   s1_addr;
  logic [DATA_W-1:0]   s1_data;

  logic [CNT_W-1:0]    count     [NUM_REGIONS];
  logic [DATA_W-1:0]   sig       [NUM_REGIONS];
  logic [CNT_W-1:0]    count_inc [NUM_REGIONS];
  logic [CNT_W-1:0]    size_w    [NUM_REGIONS];
  logic [DATA_W-1:0]   exp_w     [NUM_REGIONS];
  logic [DATA_W-1:0]   sig_next  [NUM_REGIONS];

  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] sel;
  logic [NUM_REGIONS-1:0] overrun;
  logic [NUM_REGIONS-1:0] seq_bad;

  logic active;
  logic arm;
  logic err_hit;

  assign active        = (state != ST_IDLE) && Enable;
  assign arm           = Enable && !enable_q;
  assign Monitor_state = state;

  // Per-region address decode, sequence check and next signature.
  generate
    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
      logic [CMP_W-1:0] base_x;
      logic [CMP_W-1:0] size_x;
      logic [CMP_W-1:0] addr_x;
      logic [CMP_W-1:0] count_x;

      assign base_x       = CMP_W'(Region_base[g*ADDR_W +: ADDR_W]);
      assign size_w[g]    = Region_size[g*CNT_W +: CNT_W];
      assign exp_w[g]     = Expected_sig[g*DATA_W +: DATA_W];
      assign size_x       = CMP_W'(size_w[g]);
      assign addr_x       = CMP_W'(s1_addr);
      assign count_x      = CMP_W'(count[g]);
      assign hit[g]       = (addr_x >= base_x) && (addr_x < (base_x + size_x));
      assign overrun[g]   = (count[g] == size_w[g]);
      assign seq_bad[g]   = (addr_x != (base_x + count_x));
      assign count_inc[g] = count[g] + CNT_W'(1);
      assign sig_next[g]  = {sig[g][DATA_W-2:0], sig[g][DATA_W-1]} ^ s1_data;
    end
  endgenerate

  // Lowest-index matching region wins when regions overlap.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (hit[i] && (sel == '0)) begin
        sel[i] = 1'b1;
      end
    end
  end

  assign err_hit = s1_valid && ((sel & (overrun | seq_bad)) != '0);

  // Stage 1: capture write strobe, address and data; edge detect on Enable.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      enable_q <= 1'b0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
    end else begin
      enable_q <= Enable;
      s1_valid <= active && !SRAM_we_n;
      s1_addr  <= SRAM_address;
      s1_data  <= SRAM_write_data;
    end
  end

  // Stage 2: state machine, region bookkeeping and registered result outputs.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state               <= ST_IDLE;
      Region_done         <= '0;
      Region_fail         <= '0;
      All_pass            <= 1'b0;
      Out_of_region_count <= '0;
      First_err_valid     <= 1'b0;
      First_err_address   <= '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        count[i] <= '0;
        sig[i]   <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          All_pass <= 1'b0;
          if (arm) begin
            state               <= ST_MON;
            Region_done         <= '0;
            Region_fail         <= '0;
            Out_of_region_count <= '0;
            First_err_valid     <= 1'b0;
            First_err_address   <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
              count[i] <= '0;
              sig[i]   <= '0;
            end
          end
        end
        default: begin
          if (!Enable) begin
            // Results stay frozen; any write still in stage 1 is dropped.
            state    <= ST_IDLE;
            All_pass <= 1'b0;
          end else begin
            if ((state == ST_MON) && (&Region_done)) begin
              state <= ST_DONE;
            end
            // All regions done implies DONE this edge or already.
            All_pass <= (&Region_done) && (Region_fail == '0) &&
                        (Out_of_region_count == '0);

            for (int i = 0; i < NUM_REGIONS; i++) begin
              if (s1_valid && sel[i]) begin
                if (overrun[i]) begin
                  Region_fail[i] <= 1'b1;
                end else begin
                  if (seq_bad[i]) begin
                    Region_fail[i] <= 1'b1;
                  end
                  count[i] <= count_inc[i];
                  sig[i]   <= sig_next[i];
                  if (count_inc[i] == size_w[i]) begin
                    Region_done[i] <= 1'b1;
                    if (sig_next[i] != exp_w[i]) begin
                      Region_fail[i] <= 1'b1;
                    end
                  end
                end
              end
            end

            if (s1_valid && (sel == '0) && (Out_of_region_count != '1)) begin
              Out_of_region_count <= Out_of_region_count + OOR_W'(1);
            end

            if (err_hit && !First_err_valid) begin
              First_err_valid   <= 1'b1;
              First_err_address <= s1_addr;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_write_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sram_write_monitor                                        |
// | Description : Bench for sram_write_monitor. Drives a 1-region instance     |
// |               (4-bit out-of-region counter) and a 3-region instance from   |
// |               shared write stimulus, compared against a behavioural model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sram_write_monitor;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int NR = 3;
  localparam int CW = 18;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic we_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [NR*AW-1:0] region_base;
  logic [NR*CW-1:0] region_size;
  logic [NR*DW-1:0] expected_sig;

  logic [0:0]    d1_done, d1_fail;
  logic          d1_pass, d1_fev;
  logic [3:0]    d1_oor;
  logic [AW-1:0] d1_fea;
  logic [1:0]    d1_state;

  logic [NR-1:0] d3_done, d3_fail;
  logic          d3_pass, d3_fev;
  logic [15:0]   d3_oor;
  logic [AW-1:0] d3_fea;
  logic [1:0]    d3_state;

  sram_write_monitor #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGIONS(1), .CNT_W(CW), .OOR_W(4)) dut1 (
    .Clock_50(clk), .Reset(rst), .Enable(enable), .SRAM_we_n(we_n),
    .SRAM_address(addr), .SRAM_write_data(wdata),
    .Region_base(region_base[AW-1:0]), .Region_size(region_size[CW-1:0]),
    .Expected_sig(expected_sig[DW-1:0]),
    .Region_done(d1_done), .Region_fail(d1_fail), .All_pass(d1_pass),
    .Out_of_region_count(d1_oor), .First_err_valid(d1_fev),
    .First_err_address(d1_fea), .Monitor_state(d1_state)
  );

  sram_write_monitor #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGIONS(NR), .CNT_W(CW), .OOR_W(16)) dut3 (
    .Clock_50(clk), .Reset(rst), .Enable(enable), .SRAM_we_n(we_n),
    .SRAM_address(addr), .SRAM_write_data(wdata),
    .Region_base(region_base), .Region_size(region_size),
    .Expected_sig(expected_sig),
    .Region_done(d3_done), .Region_fail(d3_fail), .All_pass(d3_pass),
    .Out_of_region_count(d3_oor), .First_err_valid(d3_fev),
    .First_err_address(d3_fea), .Monitor_state(d3_state)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Region configuration shared by both instances (dut1 sees region 0 only).
  int unsigned   c_base [NR];
  int unsigned   c_size [NR];
  logic [DW-1:0] c_exp  [NR];

  // Reference model, index 0 = dut1, index 1 = dut3. State: 0 idle, 1 mon, 2 done.
  int unsigned   m_cnt  [2][NR];
  logic [DW-1:0] m_sig  [2][NR];
  bit            m_done [2][NR];
  bit            m_fail [2][NR];
  int unsigned   m_oor  [2];
  bit            m_fev  [2];
  int unsigned   m_fea  [2];
  int            m_st   [2];
  int unsigned   m_nreg [2] = '{1, 3};
  int unsigned   m_omax [2] = '{15, 65535};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signature rule: rotate left by one, then XOR the new data word.
  function automatic logic [DW-1:0] fold(input logic [DW-1:0] s, input logic [DW-1:0] d);
    int unsigned v;
    v = int'(s);
    v = ((v * 2) % 65536) + (v / 32768);
    return DW'(v) ^ d;
  endfunction

  task automatic push_cfg();
    for (int i = 0; i < NR; i++) begin
      region_base[i*AW +: AW]  = AW'(c_base[i]);
      region_size[i*CW +: CW]  = CW'(c_size[i]);
      expected_sig[i*DW +: DW] = c_exp[i];
    end
  endtask

  task automatic m_clear(input int st);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) begin
        m_cnt[k][i] = 0; m_sig[k][i] = '0; m_done[k][i] = 0; m_fail[k][i] = 0;
      end
      m_oor[k] = 0; m_fev[k] = 0; m_fea[k] = 0; m_st[k] = st;
    end
  endtask

  task automatic m_write(input int unsigned a, input logic [DW-1:0] d);
    for (int k = 0; k < 2; k++) begin
      int r;
      bit all;
      if (m_st[k] == 0) continue;
      r = -1;
      for (int i = 0; i < int'(m_nreg[k]); i++)
        if (r < 0 && a >= c_base[i] && a < c_base[i] + c_size[i]) r = i;
      if (r < 0) begin
        if (m_oor[k] < m_omax[k]) m_oor[k]++;
      end else if (m_cnt[k][r] == c_size[r]) begin
        m_fail[k][r] = 1;
        if (!m_fev[k]) begin m_fev[k] = 1; m_fea[k] = a; end
      end else begin
        if (a != c_base[r] + m_cnt[k][r]) begin
          m_fail[k][r] = 1;
          if (!m_fev[k]) begin m_fev[k] = 1; m_fea[k] = a; end
        end
        m_sig[k][r] = fold(m_sig[k][r], d);
        m_cnt[k][r]++;
        if (m_cnt[k][r] == c_size[r]) begin
          m_done[k][r] = 1;
          if (m_sig[k][r] != c_exp[r]) m_fail[k][r] = 1;
        end
      end
      all = 1;
      for (int i = 0; i < int'(m_nreg[k]); i++) if (!m_done[k][i]) all = 0;
      if (m_st[k] == 1 && all) m_st[k] = 2;
    end
  endtask

  task automatic check_all(input string tag);
    logic [NR-1:0] dv [2];
    logic [NR-1:0] fv [2];
    bit pass [2];
    for (int k = 0; k < 2; k++) begin
      dv[k] = '0; fv[k] = '0;
      for (int i = 0; i < int'(m_nreg[k]); i++) begin
        dv[k][i] = m_done[k][i]; fv[k][i] = m_fail[k][i];
      end
      pass[k] = (m_st[k] == 2) && (fv[k] == '0) && (m_oor[k] == 0);
    end
    chk({tag, " d1.done"},  32'(d1_done),  32'(dv[0]));
    chk({tag, " d1.fail"},  32'(d1_fail),  32'(fv[0]));
    chk({tag, " d1.pass"},  32'(d1_pass),  32'(pass[0]));
    chk({tag, " d1.oor"},   32'(d1_oor),   32'(m_oor[0]));
    chk({tag, " d1.fev"},   32'(d1_fev),   32'(m_fev[0]));
    chk({tag, " d1.fea"},   32'(d1_fea),   32'(m_fea[0]));
    chk({tag, " d1.state"}, 32'(d1_state), 32'(m_st[0]));
    chk({tag, " d3.done"},  32'(d3_done),  32'(dv[1]));
    chk({tag, " d3.fail"},  32'(d3_fail),  32'(fv[1]));
    chk({tag, " d3.pass"},  32'(d3_pass),  32'(pass[1]));
    chk({tag, " d3.oor"},   32'(d3_oor),   32'(m_oor[1]));
    chk({tag, " d3.fev"},   32'(d3_fev),   32'(m_fev[1]));
    chk({tag, " d3.fea"},   32'(d3_fea),   32'(m_fea[1]));
    chk({tag, " d3.state"}, 32'(d3_state), 32'(m_st[1]));
  endtask

  // One write per call, driven at a falling edge and sampled at the next rising edge.
  task automatic wr(input int unsigned a, input logic [DW-1:0] d);
    we_n = 1'b0; addr = AW'(a); wdata = d;
    m_write(a, d);
    @(negedge clk);
  endtask

  // Two rising edges after the last sampled write, then compare everything.
  task automatic drain_check(input string tag);
    we_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic arm();
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    m_clear(1);
  endtask

  task automatic set_one_region(input int unsigned size, input logic [DW-1:0] e);
    c_base[0] = 0; c_size[0] = size; c_exp[0] = e;
    for (int i = 1; i < NR; i++) begin c_base[i] = 0; c_size[i] = 0; c_exp[i] = '0; end
    push_cfg();
  endtask

  // Interleaved sequential fill of every region, with optional stray writes.
  task automatic run_frame(input string tag, input int stray_pct, input bit corrupt);
    logic [DW-1:0] dq [NR][$];
    int unsigned idx [NR];
    bit left;
    for (int i = 0; i < NR; i++) begin
      logic [DW-1:0] s;
      dq[i].delete();
      s = '0;
      idx[i] = 0;
      for (int j = 0; j < int'(c_size[i]); j++) begin
        dq[i].push_back(DW'($urandom));
        s = fold(s, dq[i][j]);
      end
      c_exp[i] = s;
      if (corrupt && $urandom_range(3) == 0) c_exp[i] = s ^ DW'(1 << $urandom_range(15));
    end
    push_cfg();
    arm();
    left = 1;
    while (left) begin
      if (int'($urandom_range(99)) < stray_pct) begin
        wr($urandom_range(127), DW'($urandom));
      end else begin
        int r;
        r = int'($urandom_range(NR - 1));
        for (int t = 0; t < NR && idx[r] >= c_size[r]; t++) r = (r + 1) % NR;
        wr(c_base[r] + idx[r], dq[r][idx[r]]);
        idx[r]++;
      end
      left = 0;
      for (int i = 0; i < NR; i++) if (idx[i] < c_size[i]) left = 1;
    end
    drain_check(tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; we_n = 1'b1; addr = '0; wdata = '0;
    set_one_region(0, '0);
    m_clear(0);
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);

    // Four writes of 1 fold to 1,3,7,F under rotate-then-XOR.
    set_one_region(4, 16'h000F);
    arm();
    for (int i = 0; i < 4; i++) wr(i, 16'h0001);
    drain_check("t1");

    // Same writes against a wrong signature.
    set_one_region(4, 16'h0004);
    arm();
    for (int i = 0; i < 4; i++) wr(i, 16'h0001);
    drain_check("t1bad");

    // Out-of-order addresses.
    set_one_region(4, 16'h000F);
    arm();
    wr(0, 1); wr(1, 1); wr(3, 1); wr(2, 1);
    drain_check("t2");

    // Enable drops while a write sits in stage 1: that write is lost.
    arm();
    wr(0, 16'h1234); wr(1, 16'h5678);
    we_n = 1'b0; addr = 2; wdata = 16'h9ABC;
    @(negedge clk);
    enable = 1'b0; we_n = 1'b1;
    m_st[0] = 0; m_st[1] = 0;
    drain_check("drop");

    // Region complete, then out-of-range, then overrun.
    begin
      logic [DW-1:0] d0, d1;
      d0 = DW'($urandom); d1 = DW'($urandom);
      set_one_region(2, fold(fold('0, d0), d1));
      arm();
      wr(0, d0); wr(1, d1);
      drain_check("t4a");
      wr(2, DW'($urandom));
      drain_check("t4b");
      wr(1, DW'($urandom));
      drain_check("t4c");
    end

    // Asynchronous reset mid-stream, then a clean re-run.
    set_one_region(4, 16'h000F);
    arm();
    for (int i = 0; i < 10; i++) wr(i % 8, DW'($urandom));
    #3 rst = 1'b1; enable = 1'b0;
    #1;
    m_clear(0);
    check_all("t5rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    arm();
    for (int i = 0; i < 4; i++) wr(i, 16'h0001);
    drain_check("t5redo");

    // Saturation of the 4-bit out-of-region counter.
    arm();
    for (int i = 0; i < 20; i++) wr(1000 + i, DW'($urandom));
    drain_check("t6");

    // Three-region frame (scaled-down layout) plus one stray at 100000.
    c_base[0] = 0;   c_size[0] = 384;
    c_base[1] = 384; c_size[1] = 192;
    c_base[2] = 576; c_size[2] = 192;
    run_frame("t3", 0, 0);
    wr(100000, DW'($urandom));
    drain_check("t3oor");

    // Random, possibly overlapping regions with stray writes.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NR; i++) begin
        c_base[i] = $urandom_range(48);
        c_size[i] = $urandom_range(12, 1);
      end
      run_frame("rand", (n % 2 == 0) ? 0 : 10, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
